// File: rtl/ctrl_pkg.sv
// Shared encodings and the ID/EX control bundle for the pipeline control unit.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ALU_R     = 3'b000,
      ALU_I     = 3'b001,
      ALU_ADD   = 3'b010,
      ALU_I_JAL = 3'b011,
      ALU_B     = 3'b100,
      ALU_U_LUI = 3'b101,
      ALU_MD    = 3'b110
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_type_e;

   typedef enum logic [1:0] {
      BR_N    = 2'b00,
      BR_JALR = 2'b01,
      BR_B    = 2'b10,
      BR_JAL  = 2'b11
   } branch_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] F7_MD     = 7'b0000001;

   typedef struct packed {
      alu_op_e    alu_op;
      imm_type_e  imm_type;
      logic       alu_rs2_sel;
      logic       pc_sel;
      logic       mem_rd_sel;
      branch_e    branch;
      logic       dm_read;
      logic       dm_write;
      logic       reg_write;
      logic       wb_data_sel;
      logic [4:0] rd;
      logic       illegal;
   } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational RV32I(+M) decode: opcode/funct7 to control bundle and register-use flags.
// Zero latency; no flow control.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit M_EXT = 1'b1
) (
   input  logic [6:0]   opcode,
   input  logic [6:0]   funct7,
   input  logic [4:0]   rd,
   output ctrl_bundle_t ctrl,
   output logic         uses_rs1,
   output logic         uses_rs2
);

   always_comb begin
      ctrl    = '0;
      ctrl.rd = rd;
      case (opcode)
         OP_R: begin
            if (funct7 == F7_MD) begin
               if (M_EXT) begin
                  ctrl.alu_op      = ALU_MD;
                  ctrl.alu_rs2_sel = 1'b1;
                  ctrl.reg_write   = 1'b1;
               end else begin
                  ctrl.illegal = 1'b1;
               end
            end else begin
               ctrl.alu_op      = ALU_R;
               ctrl.alu_rs2_sel = 1'b1;
               ctrl.reg_write   = 1'b1;
            end
         end
         OP_LOAD: begin
            ctrl.alu_op      = ALU_ADD;
            ctrl.imm_type    = IMM_I;
            ctrl.dm_read     = 1'b1;
            ctrl.wb_data_sel = 1'b1;
            ctrl.reg_write   = 1'b1;
         end
         OP_IMM: begin
            ctrl.alu_op    = ALU_I;
            ctrl.imm_type  = IMM_I;
            ctrl.reg_write = 1'b1;
         end
         OP_JALR: begin
            ctrl.alu_op     = ALU_I_JAL;
            ctrl.imm_type   = IMM_I;
            ctrl.mem_rd_sel = 1'b1;
            ctrl.branch     = BR_JALR;
            ctrl.reg_write  = 1'b1;
         end
         OP_STORE: begin
            ctrl.alu_op   = ALU_ADD;
            ctrl.imm_type = IMM_S;
            ctrl.dm_write = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.alu_op      = ALU_B;
            ctrl.imm_type    = IMM_B;
            ctrl.alu_rs2_sel = 1'b1;
            ctrl.branch      = BR_B;
         end
         OP_AUIPC: begin
            ctrl.alu_op     = ALU_ADD;
            ctrl.imm_type   = IMM_U;
            ctrl.pc_sel     = 1'b1;
            ctrl.mem_rd_sel = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         OP_LUI: begin
            ctrl.alu_op    = ALU_U_LUI;
            ctrl.imm_type  = IMM_U;
            ctrl.reg_write = 1'b1;
         end
         OP_JAL: begin
            ctrl.alu_op     = ALU_ADD;
            ctrl.imm_type   = IMM_J;
            ctrl.mem_rd_sel = 1'b1;
            ctrl.branch     = BR_JAL;
            ctrl.reg_write  = 1'b1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

   // Register-use is decided by opcode alone, so an illegal MD encoding still reads rs1/rs2.
   assign uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign uses_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage decode into the ID/EX register with load-use, flush-bubble and MD sequencing control.
// One cycle ID->EX; stall_out holds PC and IF/ID on load-use or while an MD op occupies EX.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter bit M_EXT      = 1'b1,
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = $clog2(MD_LATENCY + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_inst,
   input  logic        ex_flush,
   output logic        stall_out,
   output logic        ex_valid,
   output logic [2:0]  ex_alu_op,
   output logic [2:0]  ex_imm_type,
   output logic        ex_alu_rs2_sel,
   output logic        ex_pc_sel,
   output logic        ex_mem_rd_sel,
   output logic [1:0]  ex_branch_signal,
   output logic        ex_dm_read,
   output logic        ex_dm_write,
   output logic        ex_reg_write,
   output logic        ex_wb_data_sel,
   output logic [4:0]  ex_rd,
   output logic        ex_illegal,
   output logic        md_start,
   output logic        md_done
);

   ctrl_bundle_t     dec;
   ctrl_bundle_t     ex_q;
   logic             ex_vld_q;
   logic             uses_rs1;
   logic             uses_rs2;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic             load_use;
   logic             ex_is_md;
   logic             md_last;
   logic             ex_hold;
   md_state_e        state;
   md_state_e        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             unused_funct3;

   ctrl_decode #(.M_EXT(M_EXT)) u_decode (
      .opcode   (id_inst[6:0]),
      .funct7   (id_inst[31:25]),
      .rd       (id_inst[11:7]),
      .ctrl     (dec),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   assign rs1           = id_inst[19:15];
   assign rs2           = id_inst[24:20];
   assign unused_funct3 = ^id_inst[14:12];

   assign load_use = id_valid & ex_vld_q & ex_q.dm_read & (ex_q.rd != 5'd0) &
                     ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));

   // EX is released on the same edge that md_done is presented.
   assign ex_is_md  = ex_vld_q & (ex_q.alu_op == ALU_MD);
   assign md_last   = (state == MD_BUSY) & (cnt == '0);
   assign ex_hold   = ex_is_md & !md_last;
   assign stall_out = load_use | ex_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_vld_q <= 1'b0;
         ex_q     <= '0;
      end else if (!ex_hold) begin
         if (ex_flush | load_use | !id_valid) begin
            ex_vld_q <= 1'b0;
            ex_q     <= '0;
         end else begin
            ex_vld_q <= 1'b1;
            ex_q     <= dec;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         MD_IDLE: begin
            if (ex_is_md) begin
               state_nxt = MD_BUSY;
               cnt_nxt   = CNT_W'(MD_LATENCY - 1);
            end
         end
         MD_BUSY: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               state_nxt = MD_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      md_start = (state == MD_IDLE) & ex_is_md;
      md_done  = md_last;
   end

   assign ex_valid         = ex_vld_q;
   assign ex_alu_op        = ex_q.alu_op;
   assign ex_imm_type      = ex_q.imm_type;
   assign ex_alu_rs2_sel   = ex_q.alu_rs2_sel;
   assign ex_pc_sel        = ex_q.pc_sel;
   assign ex_mem_rd_sel    = ex_q.mem_rd_sel;
   assign ex_branch_signal = ex_q.branch;
   assign ex_dm_read       = ex_q.dm_read;
   assign ex_dm_write      = ex_q.dm_write;
   assign ex_reg_write     = ex_q.reg_write;
   assign ex_wb_data_sel   = ex_q.wb_data_sel;
   assign ex_rd            = ex_q.rd;
   assign ex_illegal       = ex_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench: two DUT lanes (M_EXT=1/LAT=4 and M_EXT=0/LAT=2) driven by directed then random streams.
module tb_pipe_ctrl_unit;

   localparam int LAT0 = 4;
   localparam int LAT1 = 2;
   localparam int NDIR = 7;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        idv [2];
   logic [31:0] inst [2];
   logic        fl [2];
   logic        stall [2], exv [2], rs2s [2], pcs [2], mrd [2];
   logic        dmr [2], dmw [2], rw [2], wb [2], ill [2], mds [2], mdd [2];
   logic [2:0]  alu [2], immt [2];
   logic [1:0]  br [2];
   logic [4:0]  rd [2];

   pipe_ctrl_unit #(.M_EXT(1'b1), .MD_LATENCY(LAT0)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_valid(idv[0]), .id_inst(inst[0]), .ex_flush(fl[0]),
      .stall_out(stall[0]), .ex_valid(exv[0]), .ex_alu_op(alu[0]), .ex_imm_type(immt[0]),
      .ex_alu_rs2_sel(rs2s[0]), .ex_pc_sel(pcs[0]), .ex_mem_rd_sel(mrd[0]),
      .ex_branch_signal(br[0]), .ex_dm_read(dmr[0]), .ex_dm_write(dmw[0]),
      .ex_reg_write(rw[0]), .ex_wb_data_sel(wb[0]), .ex_rd(rd[0]), .ex_illegal(ill[0]),
      .md_start(mds[0]), .md_done(mdd[0]));

   pipe_ctrl_unit #(.M_EXT(1'b0), .MD_LATENCY(LAT1)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid(idv[1]), .id_inst(inst[1]), .ex_flush(fl[1]),
      .stall_out(stall[1]), .ex_valid(exv[1]), .ex_alu_op(alu[1]), .ex_imm_type(immt[1]),
      .ex_alu_rs2_sel(rs2s[1]), .ex_pc_sel(pcs[1]), .ex_mem_rd_sel(mrd[1]),
      .ex_branch_signal(br[1]), .ex_dm_read(dmr[1]), .ex_dm_write(dmw[1]),
      .ex_reg_write(rw[1]), .ex_wb_data_sel(wb[1]), .ex_rd(rd[1]), .ex_illegal(ill[1]),
      .md_start(mds[1]), .md_done(mdd[1]));

   typedef struct packed {
      logic       vld;
      logic [2:0] alu, imm;
      logic       rs2s, pcs, mrd;
      logic [1:0] br;
      logic       dmr, dmw, rw, wb;
      logic [4:0] rd;
      logic       ill;
   } bun_t;

   typedef struct packed {
      bun_t ex;
      logic stall, mds, mdd;
   } obs_t;

   obs_t q0 [$];
   obs_t q1 [$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   bit   quiet = 1'b0;

   // Reference model state: EX occupant and how many cycles it has sat in EX.
   bun_t        m_ex [2];
   int          m_age [2];
   logic [31:0] cur [2];
   bit          have [2];
   bit          cur_dir [2];
   bit          cur_fl [2];
   int          di [2];

   logic [31:0] dir_inst [NDIR] = '{32'h00500093, 32'h0000A103, 32'h001101B3, 32'h02208233,
                                    32'h02208233, 32'h0020A023, 32'h0000007F};
   bit          dir_fl [NDIR]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   function automatic bun_t ref_dec(input logic [31:0] i, input bit mext);
      bun_t b = '0;
      b.vld = 1'b1;
      b.rd  = i[11:7];
      case (i[6:0])
         7'b0110011: begin
            if (i[31:25] == 7'b0000001 && !mext) b.ill = 1'b1;
            else begin
               b.alu  = (i[31:25] == 7'b0000001) ? 3'b110 : 3'b000;
               b.rs2s = 1'b1; b.rw = 1'b1;
            end
         end
         7'b0000011: begin b.alu = 3'b010; b.dmr = 1'b1; b.wb = 1'b1; b.rw = 1'b1; end
         7'b0010011: begin b.alu = 3'b001; b.rw = 1'b1; end
         7'b1100111: begin b.alu = 3'b011; b.mrd = 1'b1; b.br = 2'b01; b.rw = 1'b1; end
         7'b0100011: begin b.alu = 3'b010; b.imm = 3'b001; b.dmw = 1'b1; end
         7'b1100011: begin b.alu = 3'b100; b.imm = 3'b010; b.rs2s = 1'b1; b.br = 2'b10; end
         7'b0010111: begin b.alu = 3'b010; b.imm = 3'b011; b.pcs = 1'b1; b.mrd = 1'b1; b.rw = 1'b1; end
         7'b0110111: begin b.alu = 3'b101; b.imm = 3'b011; b.rw = 1'b1; end
         7'b1101111: begin b.alu = 3'b010; b.imm = 3'b100; b.mrd = 1'b1; b.br = 2'b11; b.rw = 1'b1; end
         default:    b.ill = 1'b1;
      endcase
      return b;
   endfunction

   function automatic bit load_use(input logic [31:0] i, input bun_t e);
      logic [6:0] op = i[6:0];
      bit u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
      bit u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
      return e.vld && e.dmr && e.rd != 5'd0 &&
             ((u1 && i[19:15] == e.rd) || (u2 && i[24:20] == e.rd));
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [10] = '{7'h33, 7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F};
      int k = int'($urandom_range(0, 11));
      logic [6:0] op;
      logic [6:0] f7 = 7'($urandom);
      if (k < 10) op = ops[k];
      else op = (k == 10) ? 7'h7F : 7'h0B;
      if (k == 0) f7 = 7'h01;
      else if (k == 1) f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
              5'($urandom_range(0, 3)), op};
   endfunction

   function automatic obs_t observe(input int l);
      obs_t o;
      o.ex = {exv[l], alu[l], immt[l], rs2s[l], pcs[l], mrd[l], br[l], dmr[l], dmw[l],
              rw[l], wb[l], rd[l], ill[l]};
      o.stall = stall[l];
      o.mds   = mds[l];
      o.mdd   = mdd[l];
      return o;
   endfunction

   task automatic push(input int l, input obs_t o);
      if (l == 0) q0.push_back(o);
      else q1.push_back(o);
   endtask

   task automatic check(input int l, input obs_t e);
      obs_t g = observe(l);
      n_total++;
      if (g.ex === e.ex) n_pass++;
      else $display("FAIL ex_bundle lane%0d cyc=%0d got=%h exp=%h", l, cyc, g.ex, e.ex);
      n_total++;
      if ({g.stall, g.mds, g.mdd} === {e.stall, e.mds, e.mdd}) n_pass++;
      else $display("FAIL stall_md lane%0d cyc=%0d got=%b exp=%b", l, cyc,
                    {g.stall, g.mds, g.mdd}, {e.stall, e.mds, e.mdd});
   endtask

   task automatic reset_lane(input int l);
      m_ex[l]  = '0;
      m_age[l] = 0;
      have[l]  = 1'b0;
      idv[l]   = 1'b0;
      inst[l]  = 32'h0;
      fl[l]    = 1'b0;
      push(l, '0);
   endtask

   task automatic drive_lane(input int l);
      int   lat  = (l == 0) ? LAT0 : LAT1;
      bit   mext = (l == 0);
      bit   f, md, hold, lu;
      obs_t o;
      if (!have[l]) begin
         if (di[l] < NDIR) begin
            cur[l] = dir_inst[di[l]]; cur_fl[l] = dir_fl[di[l]];
            cur_dir[l] = 1'b1; have[l] = 1'b1; di[l]++;
         end else if (!quiet && $urandom_range(0, 4) != 0) begin
            cur[l] = rand_inst(); cur_dir[l] = 1'b0; have[l] = 1'b1;
         end
      end
      if (have[l] && cur_dir[l]) f = cur_fl[l];
      else f = !quiet && di[l] >= NDIR && $urandom_range(0, 9) == 0;
      md   = m_ex[l].vld && m_ex[l].alu == 3'b110;
      hold = md && m_age[l] < lat;
      lu   = have[l] && load_use(cur[l], m_ex[l]);
      o.ex    = m_ex[l];
      o.stall = lu || hold;
      o.mds   = md && m_age[l] == 0;
      o.mdd   = md && m_age[l] == lat;
      push(l, o);
      idv[l]  = have[l];
      inst[l] = have[l] ? cur[l] : 32'($urandom);
      fl[l]   = f;
      if (hold) m_age[l]++;
      else if (f || lu || !have[l]) begin m_ex[l] = '0; m_age[l] = 0; end
      else begin m_ex[l] = ref_dec(cur[l], mext); m_age[l] = 0; end
      if (have[l] && (f || !(lu || hold))) have[l] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) check(0, q0.pop_front());
      if (q1.size() > 0) check(1, q1.pop_front());
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      bit reached = 1'b0;
      rst_n = 1'b0;
      for (int l = 0; l < 2; l++) begin di[l] = 0; cur[l] = 32'h0; cur_dir[l] = 1'b0; cur_fl[l] = 1'b0; end
      repeat (3) begin
         @(posedge clk); #1;
         reset_lane(0); reset_lane(1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive_lane(0); drive_lane(1);
      repeat (1800) begin
         @(posedge clk); #1;
         drive_lane(0); drive_lane(1);
      end

      // Steer lane 0 into the middle of an MD op, then reset asynchronously.
      quiet = 1'b1;
      for (int k = 0; k < 60 && !reached; k++) begin
         @(posedge clk); #1;
         if (!have[0]) begin cur[0] = 32'h02208233; cur_dir[0] = 1'b0; have[0] = 1'b1; end
         drive_lane(0); drive_lane(1);
         reached = m_ex[0].vld && m_ex[0].alu == 3'b110 && m_age[0] == 2;
      end
      n_total++;
      if (reached) n_pass++;
      else $display("FAIL md_busy_reach got=0 required=1 within 60 cycles");
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      for (int l = 0; l < 2; l++) begin
         n_total++;
         if (observe(l) === '0) n_pass++;
         else $display("FAIL async_reset lane%0d got=%h required=0", l, observe(l));
      end
      repeat (2) begin
         @(posedge clk); #1;
         reset_lane(0); reset_lane(1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive_lane(0); drive_lane(1);
      repeat (12) begin
         @(posedge clk); #1;
         drive_lane(0); drive_lane(1);
      end
      quiet = 1'b0;
      repeat (60) begin
         @(posedge clk); #1;
         drive_lane(0); drive_lane(1);
      end
      for (int k = 0; k < 5 && (q0.size() > 0 || q1.size() > 0); k++) @(posedge clk);
      n_total++;
      if (q0.size() == 0 && q1.size() == 0) n_pass++;
      else $display("FAIL drain got=%0d/%0d left required=0", q0.size(), q1.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised successor to the combinational opcode decoder. It decodes the ID-stage instruction (RV32I, optionally RV32M) and registers the control bundle into the ID/EX pipeline register. It also detects load-use hazards, inserts bubbles on branch flush, and sequences multi-cycle MUL/DIV with an internal FSM that stalls the front end. It sits between the IF/ID register and the EX stage.

Parameters:
M_EXT, 1, 1 enables MUL/DIV decode (opcode 0110011 with funct7=0000001); 0 flags it illegal.
MD_LATENCY, 4, cycles the MD unit needs per op; legal range >=1.
CNT_W, $clog2(MD_LATENCY+1), width of the MD countdown counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a live instruction
id_inst  in  32  instruction in ID
ex_flush  in  1  branch/jump taken in EX; kill the ID instruction
stall_out  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX slot holds a live instruction
ex_alu_op  out  3  R=000, I=001, ADD=010, I_JAL=011, B=100, U_LUI=101, MD=110
ex_imm_type  out  3  I=000, S=001, B=010, U=011, J=100
ex_alu_rs2_sel  out  1  1 rs2, 0 imm
ex_pc_sel  out  1  1 pc+imm
ex_mem_rd_sel  out  1  1 pc-based rd value
ex_branch_signal  out  2  N=00, JALR=01, B=10, JAL=11
ex_dm_read, ex_dm_write, ex_reg_write, ex_wb_data_sel  out  1 each  memory and writeback controls
ex_rd  out  5  destination register
ex_illegal  out  1  registered illegal-opcode flag
md_start  out  1  one-cycle pulse launching the MD unit
md_done  out  1  one-cycle pulse; MD result valid, EX may advance

Behaviour:
- Reset: every ex_* output is 0, md_start/md_done are 0, FSM is IDLE, counter is 0.
- Decode (combinational, by opcode):
  - R: ALU R, rs2, reg_write.
  - Load: ADD, imm I, dm_read, wb_data_sel, reg_write.
  - OP-IMM: I, imm I, reg_write.
  - JALR: I_JAL, imm I, mem_rd_sel, branch 01, reg_write.
  - Store: ADD, imm S, dm_write, branch 00.
  - Branch: B, imm B, rs2, branch 10.
  - AUIPC: ADD, imm U, pc_sel, mem_rd_sel, reg_write.
  - LUI: U_LUI, imm U, reg_write.
  - JAL: ADD, imm J, mem_rd_sel, branch 11, reg_write.
  - MD (M_EXT=1): MD, rs2, reg_write.
  - Other: all enables 0, illegal=1.
- Register-use rules:
  - uses_rs1 holds for every opcode except LUI, AUIPC and JAL.
  - uses_rs2 holds for R, MD, Store and Branch.
- Load-use hazard: lu = id_valid & ex_valid & ex_dm_read & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- ex_hold = ex_valid & ex_alu_op==MD & !(state==BUSY & cnt==0).
- stall_out = lu | ex_hold.
- ID/EX update priority, evaluated per clock:
  - ex_hold: EX retains its contents.
  - else ex_flush or lu or !id_valid: insert a bubble. The bubble has valid=0 and all enables, illegal and branch equal to 0.
  - else: latch the decoded bundle with valid=1.
- A bubble must never carry reg_write, dm_read or dm_write.
- MD FSM:
  - IDLE: when ex_valid & MD, pulse md_start, load cnt=MD_LATENCY-1, go to BUSY.
  - BUSY: if cnt!=0, decrement. If cnt==0, pulse md_done, go to IDLE; EX is released on that same edge.
  - EX occupancy per MD op is exactly MD_LATENCY+1 cycles.
- Back-to-back MD ops: the second op enters EX on release and its IDLE detection restarts the sequence. No lost md_start.
- Simultaneous flush and ex_hold: EX holds and the ID instruction is killed (stall_out=1 still). Upstream must not reissue.
- Reset mid-MD: FSM returns to IDLE, EX becomes a bubble, no md_done pulse.

Decomposition:
- Shared package ctrl_pkg holds:
  - ALU-op, imm-type and branch-signal enums.
  - Opcode localparams.
  - The packed ctrl_bundle_t struct (all ex_* fields).
- One sub-module, ctrl_decode, holds the pure combinational decode (opcode/funct7 -> ctrl_bundle_t, uses_rs1/2, illegal).
- Hazard logic, the ID/EX register and the MD FSM live in pipe_ctrl_unit.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093) with id_valid=1 -> next cycle ex_valid=1, alu_op=001, imm_type=000, reg_write=1, rd=1, stall_out=0.
- LW x2,0(x1) followed by ADD x3,x2,x1 -> stall_out=1 for one cycle, one bubble (ex_valid=0) in EX, ADD reaches EX the cycle after.
- MUL x4,x1,x2 with MD_LATENCY=4 -> md_start one cycle after entry, md_done 4 cycles later, stall_out high for 4 cycles, EX held 5 cycles.
- ex_flush=1 alongside a valid SW -> next EX is a bubble with dm_write=0 and branch=00.
- Opcode 0x7F, then MUL with M_EXT=0 -> ex_illegal=1 and all enables 0 in both cases.
- rst_n pulled low during MD BUSY -> all outputs 0 asynchronously; after release FSM is IDLE and md_done never fires.
